// File: rtl/micro_timer_pkg.sv
// Shared constants for the microsecond interval timer: state encodings and
// the start-acceptance rule, kept here so game-flow FSMs can reuse them.
package micro_timer_pkg;

    // Default width of timestamps, durations and elapsed counts.
    localparam int TW_DEFAULT = 32;

    // Interval FSM states. Encodings are fixed so other FSMs can decode them.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } timer_state_e;

    // A start request is honoured only when no cancel arrives in the same
    // cycle: cancel always wins.
    function automatic logic start_accepted(input logic start, input logic cancel);
        return start & ~cancel;
    endfunction

endpackage : micro_timer_pkg

// File: rtl/micro_elapsed.sv
// Wrap-safe elapsed-time arithmetic. Modulo-2^TW subtraction of the start
// stamp from the current time gives the right answer across a counter wrap,
// and the comparison against the duration is then plain unsigned.
module micro_elapsed #(
    parameter int TW = 32
) (
    input  logic [TW-1:0] now,
    input  logic [TW-1:0] stamp,
    input  logic [TW-1:0] dur,
    output logic [TW-1:0] elapsed,
    output logic          expired
);

    // Subtract-and-compare; purely combinational, no state.
    always_comb begin
        elapsed = now - stamp;
        expired = (elapsed >= dur);
    end

endmodule : micro_elapsed

// File: rtl/micro_timer.sv
// Microsecond interval timer. Latches a timestamp and duration when a start
// is accepted, tracks elapsed microseconds against a free-running time base,
// and emits a one-cycle done pulse at expiry. Cancel aborts silently; a start
// while running restarts the interval. All outputs come straight from flops.
module micro_timer
    import micro_timer_pkg::*;
#(
    parameter int TW = TW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [TW-1:0] timeMicro,
    input  logic          start,
    input  logic          cancel,
    input  logic [TW-1:0] duration,
    output logic          busy,
    output logic          done,
    output logic [TW-1:0] elapsed
);

    timer_state_e  r_state;
    timer_state_e  w_next;
    logic          r_busy;
    logic          r_done;
    logic [TW-1:0] r_stamp;
    logic [TW-1:0] r_dur;
    logic [TW-1:0] r_elapsed;

    logic          w_accept;
    logic          w_load;
    logic          w_track;
    logic [TW-1:0] w_elapsed;
    logic          w_expired;

    assign w_accept = start_accepted(start, cancel);

    micro_elapsed #(
        .TW (TW)
    ) u_elapsed (
        .now     (timeMicro),
        .stamp   (r_stamp),
        .dur     (r_dur),
        .elapsed (w_elapsed),
        .expired (w_expired)
    );

    // Next-state and datapath control decode.
    always_comb begin
        // NOTE: every output of this block is given a default first so no
        // path through the case leaves a signal unassigned and infers a latch.
        w_next  = r_state;
        w_load  = 1'b0;
        w_track = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next = RUN;
                    w_load = 1'b1;
                end
            end
            RUN: begin
                if (cancel) begin
                    // Abort: elapsed stays frozen, no done pulse follows.
                    w_next = IDLE;
                end else if (start) begin
                    // Restart: re-latch and keep running.
                    w_load = 1'b1;
                end else begin
                    w_track = 1'b1;
                    if (w_expired) begin
                        w_next = DONE;
                    end
                end
            end
            DONE: begin
                // The done pulse is already on the output this cycle; a start
                // here is taken exactly as from IDLE.
                if (w_accept) begin
                    w_next = RUN;
                    w_load = 1'b1;
                end else begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // State register with status flags registered from the next state.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next == RUN);
            r_done  <= (w_next == DONE);
        end
    end

    // Interval datapath: stamp, duration and elapsed registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stamp   <= '0;
            r_dur     <= '0;
            r_elapsed <= '0;
        end else if (w_load) begin
            r_stamp   <= timeMicro;
            r_dur     <= duration;
            r_elapsed <= '0;
        end else if (w_track) begin
            r_elapsed <= w_elapsed;
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign elapsed = r_elapsed;

endmodule : micro_timer

// File: tb/tb_micro_timer.sv
// Self-checking bench for micro_timer. Stimulus pushes the elapsed value
// expected at each done pulse into a queue; a monitor pops and compares
// whenever the DUT pulses done. Direct checks cover busy/elapsed sequencing.
`timescale 1ns/1ps
module tb_micro_timer;

    localparam int TW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [TW-1:0] timeMicro;
    logic          start;
    logic          cancel;
    logic [TW-1:0] duration;
    logic          busy;
    logic          done;
    logic [TW-1:0] elapsed;

    int n_cmp = 0;
    int n_err = 0;
    logic [TW-1:0] exp_q[$];

    micro_timer #(.TW(TW)) dut (
        .clk       (clk),
        .rst       (rst),
        .timeMicro (timeMicro),
        .start     (start),
        .cancel    (cancel),
        .duration  (duration),
        .busy      (busy),
        .done      (done),
        .elapsed   (elapsed)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock edge; time base moves one microsecond per cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        timeMicro = timeMicro + 1;
    endtask

    // Tick until done is seen at a falling edge, bounded by max cycles.
    task automatic ticks_until_done(input int max, output int n);
        n = 0;
        do begin
            tick();
            n++;
            @(negedge clk);
        end while (!done && n < max);
        check("done_within_budget", {31'd0, done}, 1);
    endtask

    // Scoreboard monitor: every done pulse must match a queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_done: elapsed %0h with no pulse expected at %0t", elapsed, $time);
                end else begin
                    check("done_elapsed", elapsed, exp_q.pop_front());
                    check("busy_low_at_done", {31'd0, busy}, 0);
                end
            end
        end
    end

    initial begin
        int n;
        rst = 1'b0; start = 1'b0; cancel = 1'b0;
        duration = '0; timeMicro = '0;

        // Reset held for three edges.
        repeat (3) tick();
        @(negedge clk);
        check("reset_busy", {31'd0, busy}, 0);
        check("reset_done", {31'd0, done}, 0);
        check("reset_elapsed", elapsed, 0);
        rst = 1'b1;
        repeat (2) tick();

        // Basic interval: start at 100 for 5 us, done with elapsed 5.
        timeMicro = 100; duration = 5; start = 1'b1;
        exp_q.push_back(5);
        tick();
        start = 1'b0;
        @(negedge clk);
        check("basic_busy_rise", {31'd0, busy}, 1);
        check("basic_elapsed_clear", elapsed, 0);
        ticks_until_done(20, n);
        check("basic_cycles_to_done", n, 5);
        tick();
        @(negedge clk);
        check("basic_done_one_cycle", {31'd0, done}, 0);

        // Wrap across 2^32: elapsed walks 0..4, done only at 4.
        timeMicro = 32'hFFFF_FFFE; duration = 4; start = 1'b1;
        exp_q.push_back(4);
        tick();
        start = 1'b0;
        for (int i = 0; i <= 4; i++) begin
            if (i > 0) tick();
            @(negedge clk);
            check("wrap_elapsed", elapsed, i);
            check("wrap_done", {31'd0, done}, (i == 4) ? 1 : 0);
            check("wrap_busy", {31'd0, busy}, (i < 4) ? 1 : 0);
        end
        repeat (2) tick();

        // Zero duration: busy one cycle, done at k+2.
        timeMicro = 500; duration = 0; start = 1'b1;
        exp_q.push_back(1);
        tick();
        start = 1'b0;
        @(negedge clk);
        check("zero_busy_k1", {31'd0, busy}, 1);
        check("zero_done_k1", {31'd0, done}, 0);
        tick();
        @(negedge clk);
        check("zero_done_k2", {31'd0, done}, 1);
        repeat (2) tick();

        // Cancel at elapsed 20: idle, no done, elapsed held.
        timeMicro = 1000; duration = 50; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (20) tick();
        @(negedge clk);
        check("cancel_pre_elapsed", elapsed, 20);
        cancel = 1'b1;
        tick();
        @(negedge clk);
        check("cancel_busy", {31'd0, busy}, 0);
        check("cancel_elapsed_frozen", elapsed, 20);
        start = 1'b1;
        tick();
        @(negedge clk);
        check("start_cancel_idle_busy", {31'd0, busy}, 0);
        start = 1'b0; cancel = 1'b0;
        repeat (60) tick();
        @(negedge clk);
        check("cancel_still_idle", {31'd0, busy}, 0);
        check("cancel_elapsed_hold", elapsed, 20);

        // Restart at elapsed 30 with 10 us: done 10 cycles after restart.
        timeMicro = 2000; duration = 50; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (30) tick();
        @(negedge clk);
        check("restart_pre_elapsed", elapsed, 30);
        duration = 10; start = 1'b1;
        tick();
        start = 1'b0;
        exp_q.push_back(10);
        @(negedge clk);
        check("restart_busy", {31'd0, busy}, 1);
        check("restart_elapsed_clear", elapsed, 0);
        ticks_until_done(60, n);
        check("restart_cycles_to_done", n, 10);

        // Start during the done cycle: accepted, 2 us interval follows.
        duration = 2; start = 1'b1;
        exp_q.push_back(2);
        tick();
        start = 1'b0;
        @(negedge clk);
        check("done_start_busy", {31'd0, busy}, 1);
        check("done_start_elapsed", elapsed, 0);
        ticks_until_done(10, n);
        check("done_start_cycles", n, 2);
        repeat (2) tick();

        // Reset while running: abort with no done pulse.
        timeMicro = 3000; duration = 8; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        @(negedge clk);
        check("rst_run_busy", {31'd0, busy}, 0);
        check("rst_run_elapsed", elapsed, 0);
        rst = 1'b1;
        repeat (12) tick();
        @(negedge clk);
        check("rst_run_no_done", {31'd0, done}, 0);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_micro_timer

// File: doc/micro_timer.md
MICRO_TIMER -- requirements
Module: micro_timer

Interface
REQ-001 Parameter: TW, 32, width of timestamp, duration and elapsed values.
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 rst  input  1  synchronous, active-low reset; sampled on rising clk.
REQ-004 timeMicro  input  TW  free-running microsecond count from the microSeconds block; wraps 2^TW-1 -> 0.
REQ-005 start  input  1  request to begin a timed interval; sampled each cycle.
REQ-006 cancel  input  1  abort the running interval.
REQ-007 duration  input  TW  interval length in microseconds; sampled only in the cycle start is accepted.
REQ-008 busy  output  1  high while an interval is running.
REQ-009 done  output  1  one-cycle pulse marking interval expiry.
REQ-010 elapsed  output  TW  microseconds since the accepted start; holds its last value when idle.

Function
REQ-011 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-012 In IDLE with start=1 and cancel=0, the block SHALL latch stamp<=timeMicro and dur<=duration, clear elapsed to 0, and enter RUN on the next edge.
REQ-013 In RUN, each cycle SHALL register elapsed <= (timeMicro - stamp) mod 2^TW, so elapsed is correct across a timeMicro wrap.
REQ-014 In RUN, when (timeMicro - stamp) mod 2^TW >= dur, the FSM SHALL enter DONE on the next edge.
REQ-015 In DONE, done SHALL be 1 for exactly one cycle, and the FSM SHALL return to IDLE on the next edge.
REQ-016 busy SHALL be 1 exactly when state is RUN.
REQ-017 done SHALL be 1 exactly when state is DONE.
REQ-018 Latency: start accepted in cycle k -> busy=1 in k+1 -> done no earlier than k+2.
REQ-019 When duration=0, done SHALL pulse in cycle k+2.
REQ-020 In RUN, cancel=1 SHALL force IDLE on the next edge, with no done pulse and elapsed frozen.
REQ-021 In RUN, start=1 with cancel=0 SHALL restart the interval: re-latch stamp and dur, clear elapsed to 0, and stay in RUN.
REQ-022 When start and cancel are both 1, cancel SHALL win in every state.
REQ-023 start in DONE SHALL be accepted exactly as in IDLE; the done pulse is still emitted that cycle.
REQ-024 timeMicro SHALL be treated as unsigned; no saturation is applied; intervals up to 2^TW-1 us are supported.

Reset
REQ-025 When rst=0 at a rising edge: state=IDLE, busy=0, done=0, elapsed=0, stamp=0, dur=0.
REQ-026 A reset during RUN or DONE SHALL abort with no done pulse, taking priority over start and cancel.

Structure
REQ-027 State encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) SHALL live in the shared blackjack constants include, for reuse by game-flow FSMs.
REQ-028 The wrap-safe subtract-and-compare SHALL be one sub-module, micro_elapsed (inputs now, stamp, dur; outputs elapsed, expired), and be purely combinational.
REQ-029 All outputs SHALL be registered; there is no combinational path from any input to any output.

Verification
REQ-030 rst=0 for 3 cycles, then rst=1 -> busy=0, done=0, elapsed=0.
REQ-031 timeMicro=100, start with duration=5 -> busy rises next cycle; done pulses once after timeMicro reaches 105; elapsed=5 at the pulse.
REQ-032 Wrap: timeMicro=32'hFFFF_FFFE, duration=4 -> done when timeMicro=2; elapsed shows 0,1,2,3,4 with no false early expiry.
REQ-033 duration=0 -> busy high for one cycle, then done in cycle k+2.
REQ-034 duration=50, cancel at elapsed=20 -> IDLE next cycle, no done, elapsed holds 20; start+cancel together in IDLE is ignored.
REQ-035 duration=50, restart at elapsed=30 with duration=10 -> done 10 us after the restart, not at 50.
